// File: rtl/bsg_mem_1rw_sync_mask_write_bit_ctrl.sv
// Requester front end for a 1RW bit-masked synchronous SRAM: ready/valid request port,
// credit-protected response FIFO. Define BSG_MEM_CTRL_INIT_EN to zero-fill the SRAM after reset.
module bsg_mem_1rw_sync_mask_write_bit_ctrl #(
    parameter int width_p       = 8,
    parameter int els_p         = 16,
    parameter int resp_els_p    = 3,
    parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     req_v_i,
    output logic                     req_ready_and_o,
    input  logic                     req_w_i,
    input  logic [addr_width_lp-1:0] req_addr_i,
    input  logic [width_p-1:0]       req_data_i,
    input  logic [width_p-1:0]       req_mask_i,

    output logic                     resp_v_o,
    output logic [width_p-1:0]       resp_data_o,
    input  logic                     resp_yumi_i,

    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    output logic [width_p-1:0]       mem_w_mask_o,
    input  logic [width_p-1:0]       mem_data_i,

    output logic                     init_done_o
);

    localparam int ptr_width_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
    localparam int cnt_width_lp = $clog2(resp_els_p + 2);
    localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(resp_els_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_full_lp = cnt_width_lp'(resp_els_p);

    logic                    in_ready;
    logic                    init_active;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    inflight_r;
    logic [width_p-1:0]      fifo_mem [resp_els_p];
    logic [ptr_width_lp-1:0] rd_ptr_r;
    logic [ptr_width_lp-1:0] wr_ptr_r;
    logic [cnt_width_lp-1:0] fifo_cnt_r;
    logic [cnt_width_lp-1:0] credit_cnt;

`ifdef BSG_MEM_CTRL_INIT_EN
    typedef enum logic {ST_INIT, ST_READY} state_e;

    localparam logic [addr_width_lp-1:0] init_last_lp = addr_width_lp'(els_p - 1);

    state_e                   state_r;
    state_e                   state_n;
    logic [addr_width_lp-1:0] init_addr_r;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= ST_INIT;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            ST_INIT:  if (init_addr_r == init_last_lp) state_n = ST_READY;
            ST_READY: state_n = ST_READY;
        endcase
    end

    always_comb begin
        in_ready    = (state_r == ST_READY);
        init_active = (state_r == ST_INIT) && !reset_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                  init_addr_r <= '0;
        else if (state_r == ST_INIT)  init_addr_r <= init_addr_r + addr_width_lp'(1);
    end

    assign init_done_o = in_ready;
`else
    // No sweep: usable as soon as reset is released.
    assign in_ready    = ~reset_i;
    assign init_active = 1'b0;
    assign init_done_o = ~reset_i;
`endif

    // Credits count buffered responses plus the read whose data lands next cycle.
    assign credit_cnt      = fifo_cnt_r + cnt_width_lp'(inflight_r);
    assign req_ready_and_o = in_ready && (credit_cnt < cnt_full_lp);
    assign accept          = req_v_i && req_ready_and_o;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        mem_v_o      = 1'b0;
        mem_w_o      = 1'b0;
        mem_addr_o   = req_addr_i;
        mem_data_o   = req_data_i;
        mem_w_mask_o = req_mask_i;
        if (init_active) begin
            mem_v_o      = 1'b1;
            mem_w_o      = 1'b1;
`ifdef BSG_MEM_CTRL_INIT_EN
            mem_addr_o   = init_addr_r;
`endif
            mem_data_o   = '0;
            mem_w_mask_o = '1;
        end else if (accept) begin
            mem_v_o = 1'b1;
            mem_w_o = req_w_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) inflight_r <= 1'b0;
        else         inflight_r <= accept && !req_w_i;
    end

    assign push        = inflight_r;
    assign pop         = resp_yumi_i && resp_v_o;
    assign resp_v_o    = (fifo_cnt_r != '0);
    assign resp_data_o = fifo_mem[rd_ptr_r];

    // NOTE: storage is not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_r] <= mem_data_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push) wr_ptr_r <= (wr_ptr_r == ptr_last_lp) ? '0 : wr_ptr_r + ptr_width_lp'(1);
            if (pop)  rd_ptr_r <= (rd_ptr_r == ptr_last_lp) ? '0 : rd_ptr_r + ptr_width_lp'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + cnt_width_lp'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - cnt_width_lp'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        resp_yumi_i |-> resp_v_o);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        push |-> ((fifo_cnt_r < cnt_full_lp) || pop));

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_ctrl.sv
// Randomized and directed bench for bsg_mem_1rw_sync_mask_write_bit_ctrl with an SRAM model
// and a queue-based response reference model.
module tb_bsg_mem_1rw_sync_mask_write_bit_ctrl;

    localparam int W  = 8;
    localparam int E  = 16;
    localparam int R  = 3;
    localparam int AW = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          req_v_i, req_ready_and_o, req_w_i;
    logic [AW-1:0] req_addr_i;
    logic [W-1:0]  req_data_i, req_mask_i;
    logic          resp_v_o, resp_yumi_i;
    logic [W-1:0]  resp_data_o;
    logic          mem_v_o, mem_w_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_data_o, mem_w_mask_o, mem_data_i;
    logic          init_done_o;

    bsg_mem_1rw_sync_mask_write_bit_ctrl #(.width_p(W), .els_p(E), .resp_els_p(R)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_ready_and_o(req_ready_and_o), .req_w_i(req_w_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i),
        .init_done_o(init_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] data;
        int           acc;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] shadow [E];
    logic [W-1:0] sram [E];
    int           cyc = 0;
    int           sweep_left = 0;
    int           sweep_seen = 0;
    int           acc_total = 0;
    int           resp_seen = 0;
    int           yumi_mode = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Environment: behavioural 1RW SRAM with one-cycle read latency.
    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o)
                sram[mem_addr_o] = (sram[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
            else
                mem_data_i <= sram[mem_addr_o];
            if (mem_w_o && !init_done_o && !reset_i) sweep_seen++;
        end
    end

    // Reference model: outstanding reads are the credits; a read is visible two cycles after accept.
    always @(posedge clk_i) begin
        bit model_ready, accept;
        if (reset_i) begin
            q.delete();
`ifdef BSG_MEM_CTRL_INIT_EN
            sweep_left = E;
`endif
        end else begin
            model_ready = (sweep_left == 0) && (q.size() < R);
            accept      = req_v_i && model_ready;
            if (sweep_left > 0) begin
                shadow[E - sweep_left] = '0;
                sweep_left--;
            end
            if (resp_yumi_i && q.size() > 0 && cyc >= q[0].acc + 2) void'(q.pop_front());
            if (accept) begin
                acc_total++;
                if (req_w_i)
                    shadow[req_addr_i] = (shadow[req_addr_i] & ~req_mask_i) | (req_data_i & req_mask_i);
                else
                    q.push_back('{data: shadow[req_addr_i], acc: cyc});
            end
        end
        cyc++;
    end

    // Compare process: every output, every cycle, on the falling edge.
    always @(negedge clk_i) begin
        bit exp_ready, exp_rv, exp_mv;
        if (reset_i) begin
            check("rst_ready", req_ready_and_o, 0);
            check("rst_resp_v", resp_v_o, 0);
            check("rst_mem_v", mem_v_o, 0);
            check("rst_mem_w", mem_w_o, 0);
            check("rst_init_done", init_done_o, 0);
        end else begin
            exp_ready = (sweep_left == 0) && (q.size() < R);
            exp_rv    = (q.size() > 0) && (cyc >= q[0].acc + 2);
            check("ready", req_ready_and_o, exp_ready);
            check("init_done", init_done_o, sweep_left == 0);
            check("resp_v", resp_v_o, exp_rv);
            if (exp_rv) check("resp_data", resp_data_o, q[0].data);
            if (sweep_left > 0) begin
                check("init_mem_v", mem_v_o, 1);
                check("init_mem_w", mem_w_o, 1);
                check("init_mem_addr", mem_addr_o, E - sweep_left);
                check("init_mem_data", mem_data_o, 0);
                check("init_mem_mask", mem_w_mask_o, {W{1'b1}});
            end else begin
                exp_mv = req_v_i && exp_ready;
                check("mem_v", mem_v_o, exp_mv);
                check("mem_w", mem_w_o, exp_mv && req_w_i);
                if (exp_mv) begin
                    check("mem_addr", mem_addr_o, req_addr_i);
                    check("mem_data", mem_data_o, req_data_i);
                    check("mem_mask", mem_w_mask_o, req_mask_i);
                end
            end
            if (resp_v_o) resp_seen++;
        end
    end

    // Consumer: yumi only while a response is offered.
    always @(posedge clk_i) begin
        #2;
        case (yumi_mode)
            1:       resp_yumi_i = resp_v_o;
            2:       resp_yumi_i = resp_v_o & ($urandom_range(0, 1) == 1);
            default: resp_yumi_i = 1'b0;
        endcase
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] m, output int waits);
        waits      = 0;
        req_v_i    = 1'b1;
        req_w_i    = w;
        req_addr_i = a;
        req_data_i = d;
        req_mask_i = m;
        @(negedge clk_i);
        while (!req_ready_and_o && waits < 200) begin
            @(negedge clk_i);
            waits++;
        end
        if (waits >= 200) check("send_timeout", 0, 1);
        @(posedge clk_i);
        #1;
        req_v_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        yumi_mode = 1;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
        @(posedge clk_i);
        #1;
        yumi_mode = 0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_init();
        int n = 0;
        @(negedge clk_i);
        while (!init_done_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) check("init_timeout", 0, 1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, a0, r0;
        logic [W-1:0] v;
        for (int i = 0; i < E; i++) begin
            v = W'($urandom);
            sram[i] = v;
`ifdef BSG_MEM_CTRL_INIT_EN
            shadow[i] = '0;
`else
            shadow[i] = v;
`endif
        end
        reset_i = 1'b1; req_v_i = 1'b0; req_w_i = 1'b0; req_addr_i = '0;
        req_data_i = '0; req_mask_i = '0; resp_yumi_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        wait_init();

`ifdef BSG_MEM_CTRL_INIT_EN
        check("sweep_writes", sweep_seen, E);
        send(0, 9, 0, 0, w);
        @(negedge clk_i);
        @(negedge clk_i);
        check("init_read_zero", resp_data_o, 8'h00);
        @(posedge clk_i); #1;
        drain();
`endif

        // Full write then read back, held until yumi.
        send(1, 3, 8'hA5, 8'hFF, w);
        send(0, 3, 8'h00, 8'h00, w);
        @(negedge clk_i);
        check("t1_c1_resp_v", resp_v_o, 0);
        @(negedge clk_i);
        check("t1_c2_resp_v", resp_v_o, 1);
        check("t1_c2_data", resp_data_o, 8'hA5);
        @(negedge clk_i);
        check("t1_hold_v", resp_v_o, 1);
        check("t1_hold_data", resp_data_o, 8'hA5);
        @(posedge clk_i); #1;
        drain();

        // Partial mask merges with existing bits.
        send(1, 5, 8'hFF, 8'hFF, w);
        send(1, 5, 8'h00, 8'h0F, w);
        send(0, 5, 8'h00, 8'h00, w);
        @(negedge clk_i);
        @(negedge clk_i);
        check("t2_data", resp_data_o, 8'hF0);
        @(posedge clk_i); #1;
        drain();

        // Streaming reads with the consumer always taking.
        yumi_mode = 1;
        r0 = resp_seen;
        for (int i = 0; i < 8; i++) begin
            send(0, AW'(i), 8'h00, 8'h00, w);
            check("t3_no_stall", w, 0);
        end
        repeat (4) @(negedge clk_i);
        check("t3_resp_count", resp_seen - r0, 8);
        @(posedge clk_i); #1;
        drain();

        // Stalled consumer: credits run out after R accepts.
        a0 = acc_total;
        req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = 4'd2;
        repeat (6) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("t4_accepts", acc_total - a0, R);
        check("t4_mem_v_stalled", mem_v_o, 0);
        check("t4_ready_low", req_ready_and_o, 0);
        @(posedge clk_i); #1;
        yumi_mode = 1;
        @(posedge clk_i); #1;
        yumi_mode = 0;
        repeat (4) @(posedge clk_i);
        #1;
        check("t4_one_more", acc_total - a0, R + 1);
        req_v_i = 1'b0;
        drain();

        // Reset with two buffered responses and one read in flight.
        send(0, 1, 0, 0, w);
        send(0, 2, 0, 0, w);
        send(0, 3, 0, 0, w);
        check("t5_pre_resp_v", resp_v_o, 1);
        reset_i = 1'b1;
        #1;
        check("t5_resp_v_drop", resp_v_o, 0);
        check("t5_ready_drop", req_ready_and_o, 0);
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        wait_init();
        repeat (4) @(negedge clk_i);
        check("t5_no_stale", resp_v_o, 0);
        @(posedge clk_i); #1;

        // Random traffic with a random consumer and one mid-run reset.
        yumi_mode = 2;
        for (int i = 0; i < 600; i++) begin
            req_v_i    = ($urandom_range(0, 3) != 0);
            req_w_i    = ($urandom_range(0, 2) == 0);
            req_addr_i = AW'($urandom_range(0, E - 1));
            req_data_i = W'($urandom);
            req_mask_i = W'($urandom);
            if (i == 300) reset_i = 1'b1;
            if (i == 302) reset_i = 1'b0;
            @(posedge clk_i);
            #1;
        end
        req_v_i = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
